// File: rtl/traffic_model_pkg.sv
// traffic_model_pkg: shared state encoding, lamp codes and LFSR constants for the country-road traffic model
package traffic_model_pkg;
  typedef enum logic [1:0] {IDLE, WAITING, DEPARTING} state_t;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN = 3'b001;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
  function automatic logic lamp_valid(input logic [2:0] l);
    return l == LAMP_RED || l == LAMP_YELLOW || l == LAMP_GREEN;
  endfunction
endpackage

// File: rtl/traffic_light_checker.sv
// traffic_light_checker: judges the six lamp inputs each cycle; country_go gates departures,
// light_error is a sticky register of any illegal combination.
module traffic_light_checker
  import traffic_model_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] country,
  input  logic [2:0] highway,
  output logic       country_go,
  output logic       light_error
);
  logic legal;
  always_comb begin
    legal = lamp_valid(country) && lamp_valid(highway) && (country == LAMP_RED || highway == LAMP_RED);
    country_go = legal && country == LAMP_GREEN;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) light_error <= 1'b0;
    else if (!legal) light_error <= 1'b1;
endmodule

// File: rtl/country_road_traffic_model.sv
// country_road_traffic_model: queues country-road cars, drives car_async, releases cars while country green.
// Optional TRAFFIC_MODEL_AUTOGEN_EN adds an LFSR that injects random arrivals.
module country_road_traffic_model
  import traffic_model_pkg::*;
#(
  parameter int QUEUE_MAX = 15,
  parameter int DEPART_CYCLES = 4,
  parameter int PASS_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              car_arrive,
  input  logic              country_red,
  input  logic              country_yellow,
  input  logic              country_green,
  input  logic              highway_red,
  input  logic              highway_yellow,
  input  logic              highway_green,
  output logic              car_async,
  output logic [3:0]        queue_count,
  output logic [PASS_W-1:0] cars_passed,
  output logic              overflow,
  output logic              light_error
);
  localparam int TW = DEPART_CYCLES > 1 ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(DEPART_CYCLES - 1);
  localparam logic [3:0] QMAX = 4'(QUEUE_MAX);
  state_t state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [3:0] count_nx;
  logic go, arrival, pop, take, drop;
  traffic_light_checker u_check (
    .clock(clock),
    .reset(reset),
    .country({country_red, country_yellow, country_green}),
    .highway({highway_red, highway_yellow, highway_green}),
    .country_go(go),
    .light_error(light_error)
  );
`ifdef TRAFFIC_MODEL_AUTOGEN_EN
  logic [7:0] lfsr;
  always_ff @(posedge clock or posedge reset)
    if (reset) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  assign arrival = car_arrive || lfsr[2:0] == 3'b000;
`else
  assign arrival = car_arrive;
`endif
  // a departure in the same cycle frees the slot, so a full queue still accepts that arrival
  always_comb begin
    pop = state == DEPARTING && go && timer == '0;
    take = arrival && (queue_count != QMAX || pop);
    drop = arrival && !take;
    count_nx = queue_count + 4'(take) - 4'(pop);
    state_nx = count_nx == '0 ? IDLE : go ? DEPARTING : WAITING;
    timer_nx = state == DEPARTING && go && timer != '0 ? timer - TW'(1) : RELOAD;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      timer <= RELOAD;
      queue_count <= '0;
      car_async <= 1'b0;
      cars_passed <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      queue_count <= count_nx;
      car_async <= count_nx != '0;
      cars_passed <= cars_passed + PASS_W'(pop);
      overflow <= overflow | drop;
    end
endmodule
